// File: rtl/rice_stream_encoder.sv
// Back-pressured Rice encoder: zig-zag fold, split by k, emit unary/stop/LSB beats.
// Optional escape codeword for long quotients is enabled by defining RICE_ESCAPE_EN.
module rice_stream_encoder #(
   parameter int SAMPLE_W = 16,
   parameter int PARAM_W  = 5,
   parameter int UNARY_W  = 16,
   parameter int ESC_Q    = 16,
   localparam int ZW      = $clog2(UNARY_W + 1),
   localparam int BW      = $clog2(UNARY_W + SAMPLE_W + 2)
) (
   input  logic                iClock,
   input  logic                iReset,
   input  logic                iValid,
   output logic                oReady,
   input  logic [SAMPLE_W-1:0] iSample,
   input  logic [PARAM_W-1:0]  iRiceParam,
   output logic                oValid,
   input  logic                iReady,
   output logic [ZW-1:0]       oZeros,
   output logic                oStop,
   output logic [SAMPLE_W-1:0] oLSB,
   output logic [PARAM_W-1:0]  oLSBBits,
   output logic [BW-1:0]       oBitsUsed,
   output logic                oEscape
);

   typedef enum logic [1:0] {IDLE, SPLIT, LAST} state_t;

   localparam logic [PARAM_W-1:0]  K_MAX   = PARAM_W'(SAMPLE_W);
   localparam logic [SAMPLE_W:0]   UNARY_X = (SAMPLE_W + 1)'(UNARY_W);
   localparam logic [SAMPLE_W-1:0] UNARY_S = SAMPLE_W'(UNARY_W);

   state_t              state_reg;
   logic                ready_en_reg;
   logic                s1_full_reg;
   logic [SAMPLE_W-1:0] s1_u_reg;
   logic [PARAM_W-1:0]  s1_k_reg;
   logic [SAMPLE_W-1:0] rem_reg;
   logic [SAMPLE_W-1:0] hold_r_reg;
   logic [PARAM_W-1:0]  hold_k_reg;

   logic                valid_reg;
   logic [ZW-1:0]       zeros_reg;
   logic                stop_reg;
   logic [SAMPLE_W-1:0] lsb_reg;
   logic [PARAM_W-1:0]  bits_reg;
   logic [BW-1:0]       used_reg;

   logic                consume;
   logic                s1_take;
   logic                accept;
   logic [SAMPLE_W-1:0] in_u;
   logic [PARAM_W-1:0]  in_k;

   logic [SAMPLE_W-1:0] ld_q;
   logic [SAMPLE_W-1:0] ld_r;
   logic                ld_split;
   logic [ZW-1:0]       ld_zeros;
   logic                ld_stop;
   logic [SAMPLE_W-1:0] ld_lsb;
   logic [PARAM_W-1:0]  ld_bits;

   function automatic logic [BW-1:0] beat_used(input logic [ZW-1:0] z, input logic s,
                                               input logic [PARAM_W-1:0] b);
      return BW'(z) + BW'(s) + BW'(b);
   endfunction

   assign consume = valid_reg & iReady;
   // The FSM pulls S1 when idle, or when the final beat of the current codeword leaves.
   assign s1_take = s1_full_reg & ((state_reg == IDLE) | ((state_reg == LAST) & consume));
   assign oReady  = ready_en_reg & (~s1_full_reg | s1_take);
   assign accept  = iValid & oReady;

   // Zig-zag fold: negative s maps to ~(2s), i.e. -2s-1.
   assign in_u = {iSample[SAMPLE_W-2:0], 1'b0} ^ {SAMPLE_W{iSample[SAMPLE_W-1]}};
   assign in_k = (iRiceParam > K_MAX) ? K_MAX : iRiceParam;

`ifdef RICE_ESCAPE_EN
   localparam logic [SAMPLE_W:0] ESC_X = (SAMPLE_W + 1)'(ESC_Q);

   logic [SAMPLE_W-1:0] s1_raw_reg;
   logic                esc_reg;
   logic                ld_esc;

   assign ld_esc = ({1'b0, ld_q} >= ESC_X);

   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         s1_raw_reg <= '0;
         esc_reg    <= 1'b0;
      end else begin
         if (accept)
            s1_raw_reg <= iSample;
         if (s1_take)
            esc_reg <= ld_esc;
      end
   end

   assign oEscape = esc_reg;
`else
   assign oEscape = 1'b0;
`endif

   always_comb begin
      ld_q     = s1_u_reg >> s1_k_reg;
      ld_r     = s1_u_reg - (ld_q << s1_k_reg);
      ld_split = 1'b0;
      ld_zeros = ZW'(ld_q);
      ld_stop  = 1'b1;
      ld_lsb   = ld_r;
      ld_bits  = s1_k_reg;
`ifdef RICE_ESCAPE_EN
      if (ld_esc) begin
         ld_zeros = ZW'(ESC_Q);
         ld_lsb   = s1_raw_reg;
         ld_bits  = K_MAX;
      end else
`endif
      if ({1'b0, ld_q} > UNARY_X) begin
         ld_split = 1'b1;
         ld_zeros = ZW'(UNARY_W);
         ld_stop  = 1'b0;
         ld_lsb   = '0;
         ld_bits  = '0;
      end
   end

   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         state_reg    <= IDLE;
         ready_en_reg <= 1'b0;
         s1_full_reg  <= 1'b0;
         s1_u_reg     <= '0;
         s1_k_reg     <= '0;
         rem_reg      <= '0;
         hold_r_reg   <= '0;
         hold_k_reg   <= '0;
         valid_reg    <= 1'b0;
         zeros_reg    <= '0;
         stop_reg     <= 1'b0;
         lsb_reg      <= '0;
         bits_reg     <= '0;
         used_reg     <= '0;
      end else begin
         ready_en_reg <= 1'b1;

         if (accept) begin
            s1_full_reg <= 1'b1;
            s1_u_reg    <= in_u;
            s1_k_reg    <= in_k;
         end else if (s1_take) begin
            s1_full_reg <= 1'b0;
         end

         case (state_reg)
            IDLE, LAST: begin
               if (s1_take) begin
                  valid_reg  <= 1'b1;
                  zeros_reg  <= ld_zeros;
                  stop_reg   <= ld_stop;
                  lsb_reg    <= ld_lsb;
                  bits_reg   <= ld_bits;
                  used_reg   <= beat_used(ld_zeros, ld_stop, ld_bits);
                  rem_reg    <= ld_q - UNARY_S;
                  hold_r_reg <= ld_r;
                  hold_k_reg <= s1_k_reg;
                  state_reg  <= ld_split ? SPLIT : LAST;
               end else if ((state_reg == LAST) && consume) begin
                  valid_reg <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            SPLIT: begin
               if (consume) begin
                  if ({1'b0, rem_reg} > UNARY_X) begin
                     zeros_reg <= ZW'(UNARY_W);
                     used_reg  <= beat_used(ZW'(UNARY_W), 1'b0, '0);
                     rem_reg   <= rem_reg - UNARY_S;
                  end else begin
                     zeros_reg <= ZW'(rem_reg);
                     stop_reg  <= 1'b1;
                     lsb_reg   <= hold_r_reg;
                     bits_reg  <= hold_k_reg;
                     used_reg  <= beat_used(ZW'(rem_reg), 1'b1, hold_k_reg);
                     state_reg <= LAST;
                  end
               end
            end
            default: begin
               state_reg <= IDLE;
               valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign oValid    = valid_reg;
   assign oZeros    = zeros_reg;
   assign oStop     = stop_reg;
   assign oLSB      = lsb_reg;
   assign oLSBBits  = bits_reg;
   assign oBitsUsed = used_reg;

endmodule

// File: tb/tb_rice_stream_encoder.sv
// Directed bench for rice_stream_encoder with hand-computed beats.
// Escape-dependent expectations follow RICE_ESCAPE_EN.
module tb_rice_stream_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        out_ready;
   logic [15:0] sample;
   logic [4:0]  rice_param;
   logic        out_valid;
   logic        in_ready;
   logic [4:0]  zeros;
   logic        stop;
   logic [15:0] lsb;
   logic [4:0]  lsb_bits;
   logic [5:0]  bits_used;
   logic        escape;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rice_stream_encoder dut (
      .iClock    (clk),
      .iReset    (rst_n),
      .iValid    (in_valid),
      .oReady    (out_ready),
      .iSample   (sample),
      .iRiceParam(rice_param),
      .oValid    (out_valid),
      .iReady    (in_ready),
      .oZeros    (zeros),
      .oStop     (stop),
      .oLSB      (lsb),
      .oLSBBits  (lsb_bits),
      .oBitsUsed (bits_used),
      .oEscape   (escape)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] s, input logic [4:0] k);
      int n;
      sample     = s;
      rice_param = k;
      in_valid   = 1'b1;
      n = 0;
      while (!out_ready && n < 20) begin
         step();
         n++;
      end
      check("send_ready", out_ready, 1);
      step();
      in_valid = 1'b0;
   endtask

   task automatic expect_beat(input string tag, input int z, input int st, input int l,
                              input int b, input int u, input int e);
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
         step();
         n++;
      end
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_zeros"}, zeros, z);
      check({tag, "_stop"},  stop, st);
      check({tag, "_lsb"},   lsb, l);
      check({tag, "_bits"},  lsb_bits, b);
      check({tag, "_used"},  bits_used, u);
      check({tag, "_esc"},   escape, e);
      $display("beat %s zeros=%0d stop=%0d lsb=%0h bits=%0d used=%0d esc=%0d",
               tag, zeros, stop, lsb, lsb_bits, bits_used, escape);
      step();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, out_valid, 0);
      check({tag, "_zeros"}, zeros, 0);
      check({tag, "_stop"},  stop, 0);
      check({tag, "_lsb"},   lsb, 0);
      check({tag, "_bits"},  lsb_bits, 0);
      check({tag, "_used"},  bits_used, 0);
      check({tag, "_esc"},   escape, 0);
      check({tag, "_ready"}, out_ready, 0);
   endtask

   initial begin
      logic [15:0] sv [4];
      int          eq [4];
      int          er [4];
      int          cnt;
      sv = '{16'd0, 16'd1, 16'hFFFF, 16'd7};
      eq = '{0, 0, 0, 3};
      er = '{0, 2, 1, 2};

      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_ready   = 1'b1;
      sample     = '0;
      rice_param = '0;

      // Reset state and ready rising one edge after release
      repeat (3) step();
      check_all_zero("reset");
      rst_n = 1'b1;
      #1;
      check("ready_before_edge", out_ready, 0);
      step();
      check("ready_after_edge", out_ready, 1);

      // k=4, -123: u=245, q=15, r=5
      send(16'hFF85, 5'd4);
      expect_beat("k4_m123", 15, 1, 5, 4, 20, 0);

      // k=0, 20: u=40
      send(16'd20, 5'd0);
`ifdef RICE_ESCAPE_EN
      expect_beat("esc20", 16, 1, 16'h0014, 16, 33, 1);
`else
      expect_beat("split20_a", 16, 0, 0, 0, 16, 0);
      expect_beat("split20_b", 16, 0, 0, 0, 16, 0);
      expect_beat("split20_c", 8, 1, 0, 0, 9, 0);
`endif

      // k=20 clamped to 16, -32768 folds to 0xFFFF
      send(16'h8000, 5'd20);
      expect_beat("clamp", 0, 1, 16'hFFFF, 16, 17, 0);

      // Back-to-back stream, k=2
      for (int i = 0; i < 6; i++) begin
         if (i < 4) begin
            sample     = sv[i];
            rice_param = 5'd2;
            in_valid   = 1'b1;
            check($sformatf("stream_ready%0d", i), out_ready, 1);
         end else begin
            in_valid = 1'b0;
         end
         if (i >= 2) begin
            check($sformatf("stream_valid%0d", i - 2), out_valid, 1);
            check($sformatf("stream_zeros%0d", i - 2), zeros, eq[i-2]);
            check($sformatf("stream_lsb%0d", i - 2), lsb, er[i-2]);
            check($sformatf("stream_bits%0d", i - 2), lsb_bits, 2);
            check($sformatf("stream_used%0d", i - 2), bits_used, eq[i-2] + 3);
            $display("beat stream%0d zeros=%0d lsb=%0h", i - 2, zeros, lsb);
         end
         step();
      end
      check("stream_drained", out_valid, 0);

      // Back-pressure: beat holds, oReady drops once S1 is occupied
      in_ready = 1'b0;
      send(16'hFF85, 5'd4);
      send(16'd3, 5'd4);
      check("bp_ready_low", out_ready, 0);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("bp_hold_valid%0d", i), out_valid, 1);
         check($sformatf("bp_hold_zeros%0d", i), zeros, 15);
         check($sformatf("bp_hold_lsb%0d", i), lsb, 5);
         check($sformatf("bp_hold_ready%0d", i), out_ready, 0);
         step();
      end
      in_ready = 1'b1;
      #1;
      check("bp_ready_release", out_ready, 1);
      expect_beat("bp_a", 15, 1, 5, 4, 20, 0);
      expect_beat("bp_b", 0, 1, 6, 4, 5, 0);
      check("bp_drained", out_valid, 0);

      // Reset mid-codeword, with a further sample waiting in S1
      send(16'd20, 5'd0);
      send(16'd7, 5'd2);
`ifndef RICE_ESCAPE_EN
      check("rst_split_first_stop", stop, 0);
`endif
      check("rst_pre_valid", out_valid, 1);
      step();
      rst_n = 1'b0;
      #1;
      check_all_zero("rst_mid");
      step();
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (out_valid) cnt++;
      end
      check("rst_no_residual", cnt, 0);
      check("rst_ready_back", out_ready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rice_stream_encoder.md
# rice_stream_encoder

Parametrised, back-pressured Rice encoder for the Stage 3 residual path. It zig-zag folds each signed residual, splits it by a per-sample Rice parameter, and emits codeword beats (unary zero count, stop bit, LSB field) to the bit packer. Long unary runs are split across several beats; optionally, an escape code bounds the codeword length. It supersedes the fixed-width single-cycle VariableRiceEncoder.

## Interface
Parameters:
- SAMPLE_W, 16: residual width, in bits.
- PARAM_W, 5: Rice parameter width. Must satisfy PARAM_W ≥ $clog2(SAMPLE_W+1).
- UNARY_W, 16: maximum number of unary zeros carried by one beat.
- ESC_Q, 16: escape quotient threshold. Only used with RICE_ESCAPE_EN. Must satisfy ESC_Q ≤ UNARY_W.

Ports:
- iClock  in  1  clock; all logic is on the rising edge.
- iReset  in  1  reset, asynchronous, active-low (0 = reset).
- iValid  in  1  input sample valid.
- oReady  out  1  encoder can accept a sample this cycle.
- iSample  in  SAMPLE_W  signed residual.
- iRiceParam  in  PARAM_W  Rice parameter k, sampled with iSample.
- oValid  out  1  output beat valid.
- iReady  in  1  downstream accepts the beat.
- oZeros  out  $clog2(UNARY_W+1)  number of leading zero bits in the beat.
- oStop  out  1  beat ends the codeword: a '1' stop bit follows the zeros, then the LSB field.
- oLSB  out  SAMPLE_W  LSB field, right-aligned.
- oLSBBits  out  PARAM_W  valid bits in oLSB. 0 when oStop=0.
- oBitsUsed  out  $clog2(UNARY_W+SAMPLE_W+2)  oZeros + oStop + oLSBBits.
- oEscape  out  1  beat is an escape codeword.

## Operation
- Input handshake: a sample is accepted on a rising edge where iValid & oReady. Output handshake: a beat is consumed on an edge where oValid & iReady.
- Fold: u = (s ≥ 0) ? 2s : −2s−1, held as SAMPLE_W bits unsigned. Example: −32768 → 65535.
- Parameter clamp: keff = min(k, SAMPLE_W). Then q = u >> keff and r = u & ((1<<keff)−1).
- Stage S1 is a one-entry input register holding u, keff and the raw sample. oReady = !S1full | S1take.
- The FSM takes the S1 entry in IDLE, or in LAST when the final beat is consumed.
- FSM states:
  - IDLE: oValid=0. If S1 is full, load it.
  - Load, q ≤ UNARY_W: final beat {zeros=q, stop=1, lsb=r, bits=keff}; go to LAST.
  - Load, q > UNARY_W: beat {zeros=UNARY_W, stop=0, bits=0}; rem = q − UNARY_W; go to SPLIT.
  - SPLIT, on consume: if rem > UNARY_W, emit another UNARY_W beat and set rem −= UNARY_W. Otherwise emit final beat {zeros=rem, stop=1, r, keff} and go to LAST.
  - LAST, on consume: if S1 is full, load it in the same edge (no bubble). Otherwise go to IDLE.
- Split example: q = 32 with UNARY_W = 16 gives beats 16/no-stop, then 16/stop.
- Beat fields hold stable while oValid & !iReady.
- The rem counter is SAMPLE_W bits wide. Arithmetic never wraps, because q ≤ 2^SAMPLE_W − 1.

## Timing
- Latency: a sample accepted at edge N presents its first beat at edge N+1 (visible in the cycle after N+1).
- Throughput: one sample per cycle while every q ≤ UNARY_W and iReady=1.
- A sample needing B beats occupies the FSM for B consumed beats. S1 buffers one further sample; oReady then drops.
- Simultaneous final-beat consume and input accept: S1 moves to the FSM and the new sample enters S1 on the same edge.
- Reset values: oValid=0, oZeros=0, oStop=0, oLSB=0, oLSBBits=0, oBitsUsed=0, oEscape=0, oReady=0. FSM is IDLE, S1 is empty.
- oReady rises one edge after iReset deasserts.
- Reset mid-codeword: aborts immediately. Partial beats and the S1 contents are discarded; no trailing beat is emitted.

## Configuration
- RICE_ESCAPE_EN defined:
  - On load, if q ≥ ESC_Q, emit a single beat {zeros=ESC_Q, stop=1, oLSB=raw two's-complement sample, oLSBBits=SAMPLE_W, oEscape=1}.
  - A non-escaped codeword never has q ≥ ESC_Q, so SPLIT is never entered.
- RICE_ESCAPE_EN undefined:
  - oEscape is tied 0 and the escape comparator is not built.
  - Long quotients use SPLIT.

## Test plan
- k=4, sample −123 (u=245, q=15, r=5) → one beat: zeros=15, stop=1, lsb=5, bits=4, bitsused=20, escape=0.
- k=0, sample 20 (u=40), RICE_ESCAPE_EN undefined → beats 16/0, 16/0, 8/1 with bits=0. bitsused = 16, 16, 9.
- k=0, sample 20, RICE_ESCAPE_EN defined → one beat: zeros=16, stop=1, lsb=0x0014, bits=16, escape=1, bitsused=33.
- k=20, sample −32768 (clamped to 16) → zeros=0, stop=1, lsb=0xFFFF, bits=16, bitsused=17.
- Stream k=2, samples 0, 1, −1, 7 with iValid held high → beats on consecutive cycles: q/r = 0/0, 0/2, 0/1, 3/2. oReady stays 1.
- Back-pressure and reset:
  - Hold iReady=0 for 3 cycles mid-stream → the beat holds stable and oReady falls after S1 fills.
  - Assert iReset low during SPLIT → all outputs go to 0 at once and no residual beats follow release.
